// File: rtl/mul_share_if.sv
// Request/response and multiplier-side signals of the shared-multiplier controller.
// The slave modport is the controller; the master modport is its surroundings.
interface mul_share_if #(
   parameter int N_REQ = 4,
   parameter int W     = 32
);
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic [N_REQ-1:0]   rsp_valid;
   logic [N_REQ-1:0]   rsp_ready;
   logic [2*W-1:0]     rsp_r;
   logic               rsp_err;
   logic               mul_valid_in;
   logic [W-1:0]       mul_a;
   logic [W-1:0]       mul_b;
   logic               mul_valid_out;
   logic [2*W-1:0]     mul_r;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_valid_out, mul_r,
      output req_ready, rsp_valid, rsp_r, rsp_err, mul_valid_in, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_valid_out, mul_r,
      input  req_ready, rsp_valid, rsp_r, rsp_err, mul_valid_in, mul_a, mul_b
   );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing of one iterative multiplier among N_REQ requesters,
// with launch pulse, completion wait, timeout abort and per-requester response.
//
// state    | meaning
// S_IDLE   | offer grant to first valid requester at/after rr pointer
// S_LAUNCH | one-cycle start pulse to the multiplier, arm timeout
// S_WAIT   | wait for mul_valid_out (ignored in first cycle) or timeout
// S_RESP   | present result to granted requester until it accepts
module mul_share_ctrl #(
   parameter int N_REQ   = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 40
) (
   input logic        clk,
   input logic        rst_n,
   mul_share_if.slave bus
);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [GW-1:0]  r_rr;
   logic [GW-1:0]  r_gnt;
   logic [TW-1:0]  r_tmr;
   logic [W-1:0]   r_mul_a;
   logic [W-1:0]   r_mul_b;
   logic [2*W-1:0] r_rsp_r;
   logic           r_rsp_err;

   logic             w_gnt_vld;
   logic [GW-1:0]    w_gnt_idx;
   logic [GW-1:0]    w_rr_nxt;
   logic             w_done;
   logic             w_tout;
   logic [N_REQ-1:0] w_req_ready;
   logic [N_REQ-1:0] w_rsp_valid;
   logic             w_mul_valid_in;

   // Descending scan so the smallest offset from the pointer wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[(int'(r_rr) + i) % N_REQ]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = GW'((int'(r_rr) + i) % N_REQ);
         end
      end
   end

   assign w_rr_nxt = (w_gnt_idx == GW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
   // Timer still at its load value means this is the first WAIT cycle.
   assign w_done   = bus.mul_valid_out && (r_tmr != TW'(TIMEOUT - 1));
   assign w_tout   = (r_tmr == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      w_req_ready    = '0;
      w_rsp_valid    = '0;
      w_mul_valid_in = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_gnt_vld && rst_n) begin
               w_req_ready[w_gnt_idx] = 1'b1;
               w_next                 = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_mul_valid_in = 1'b1;
            w_next         = S_WAIT;
         end
         S_WAIT: begin
            if (w_done || w_tout) w_next = S_RESP;
         end
         S_RESP: begin
            w_rsp_valid[r_gnt] = 1'b1;
            if (bus.rsp_ready[r_gnt]) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr      <= '0;
         r_gnt     <= '0;
         r_tmr     <= '0;
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_rsp_r   <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_mul_a <= bus.req_a[int'(w_gnt_idx)*W +: W];
                  r_mul_b <= bus.req_b[int'(w_gnt_idx)*W +: W];
                  r_gnt   <= w_gnt_idx;
                  r_rr    <= w_rr_nxt;
               end
            end
            S_LAUNCH: r_tmr <= TW'(TIMEOUT - 1);
            S_WAIT: begin
               if (w_done) begin
                  r_rsp_r   <= bus.mul_r;
                  r_rsp_err <= 1'b0;
               end else if (w_tout) begin
                  r_rsp_r   <= '0;
                  r_rsp_err <= 1'b1;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready    = w_req_ready;
   assign bus.rsp_valid    = w_rsp_valid;
   assign bus.mul_valid_in = w_mul_valid_in;
   assign bus.mul_a        = r_mul_a;
   assign bus.mul_b        = r_mul_b;
   assign bus.rsp_r        = r_rsp_r;
   assign bus.rsp_err      = r_rsp_err;
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: multiplier model with selectable latency/behaviour,
// transaction-level reference model checked every cycle, plus directed scenarios.
module tb_mul_share_ctrl;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int TMO = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_share_if #(.N_REQ(N), .W(W)) bus ();
   mul_share_ctrl #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // mode 0: valid_out drops at start; 1: stays high one extra cycle; 2: never completes
   int          mul_mode = 0;
   int          mul_lat  = 1;
   bit          m_busy;
   bit          m_first;
   int          m_cnt;
   logic [63:0] m_prod;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mul_valid_out <= 1'b0;
         bus.mul_r         <= '0;
         m_busy            <= 1'b0;
         m_first           <= 1'b0;
         m_cnt             <= 0;
         m_prod            <= '0;
      end else if (bus.mul_valid_in) begin
         m_busy  <= (mul_mode != 2);
         m_cnt   <= mul_lat - 1;
         m_prod  <= {32'b0, bus.mul_a} * {32'b0, bus.mul_b};
         m_first <= 1'b1;
         if (mul_mode != 1) bus.mul_valid_out <= 1'b0;
      end else begin
         m_first <= 1'b0;
         if (m_first && mul_mode == 1) bus.mul_valid_out <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 0) begin
               bus.mul_valid_out <= 1'b1;
               bus.mul_r         <= m_prod;
               m_busy            <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   // Reference model: transaction-level view of what the controller must do.
   int          grants[$];
   logic [63:0] results[$];
   logic        errs[$];
   int          n_launch = 0;
   int          cyc = 0;
   int          md_rr = 0;
   int          md_g = 0;
   int          md_hs_cyc = 0;
   int          md_launch_cyc = 0;
   int          md_lat = 0;
   bit          md_inflight = 1'b0;
   bit          md_rsp_on = 1'b0;
   bit          md_err = 1'b0;
   logic [63:0] md_a = '0;
   logic [63:0] md_b = '0;
   logic [N-1:0] hs;
   logic [N-1:0] eh;
   int          g;

   function automatic int pick(input int rr, input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[(rr + i) % N]) return (rr + i) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         md_inflight = 1'b0;
         md_rsp_on   = 1'b0;
         md_rr       = 0;
      end else begin
         cyc++;
         check("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
         check("rspv_onehot", 64'($countones(bus.rsp_valid) <= 1), 64'd1);
         if (md_inflight) check("ready_busy", bus.req_ready, '0);
         hs = bus.req_valid & bus.req_ready;
         if (hs != '0) begin
            g = pick(md_rr, bus.req_valid);
            eh = '0;
            if (g >= 0) eh[g] = 1'b1;
            check("grant", hs, eh);
            if (g >= 0) begin
               md_g        = g;
               md_a        = 64'(bus.req_a[g*W +: W]);
               md_b        = 64'(bus.req_b[g*W +: W]);
               md_inflight = 1'b1;
               md_hs_cyc   = cyc;
               md_rr       = (g + 1) % N;
               grants.push_back(g);
            end
         end
         if (bus.mul_valid_in) begin
            check("launch_time", 64'(cyc - md_hs_cyc), 64'd1);
            check("mul_a", bus.mul_a, md_a);
            check("mul_b", bus.mul_b, md_b);
            md_launch_cyc = cyc;
            md_lat        = (mul_mode == 2) ? TMO + 1 : mul_lat + 2;
            md_err        = (mul_mode == 2);
            n_launch++;
         end
         if (bus.rsp_valid != '0) begin
            eh = '0;
            eh[md_g] = 1'b1;
            check("rsp_inflight", 64'(md_inflight), 64'd1);
            check("rsp_line", bus.rsp_valid, eh);
            if (!md_rsp_on) begin
               check("rsp_latency", 64'(cyc - md_launch_cyc), 64'(md_lat));
               md_rsp_on = 1'b1;
            end
            check("rsp_err", bus.rsp_err, md_err);
            check("rsp_r", bus.rsp_r, md_err ? 64'd0 : md_a * md_b);
            if (bus.rsp_ready[md_g]) begin
               md_inflight = 1'b0;
               md_rsp_on   = 1'b0;
               results.push_back(bus.rsp_r);
               errs.push_back(bus.rsp_err);
            end
         end
      end
   end

   task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.req_a[k*W +: W] = a;
      bus.req_b[k*W +: W] = b;
      bus.req_valid[k]    = 1'b1;
   endtask

   task automatic wait_grants(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (grants.size() >= n) break;
         @(posedge clk); #1;
      end
      check("wait_grants", 64'(grants.size() >= n), 64'd1);
      bus.req_valid = '0;
   endtask

   task automatic wait_results(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (results.size() >= n) break;
         @(posedge clk); #1;
      end
      check("wait_results", 64'(results.size() >= n), 64'd1);
   endtask

   task automatic clear_log();
      grants.delete();
      results.delete();
      errs.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_ready"}, bus.req_ready, '0);
      check({tag, "_rsp_valid"}, bus.rsp_valid, '0);
      check({tag, "_rsp_r"}, bus.rsp_r, '0);
      check({tag, "_rsp_err"}, bus.rsp_err, '0);
      check({tag, "_mul_vin"}, bus.mul_valid_in, '0);
      check({tag, "_mul_a"}, bus.mul_a, '0);
      check({tag, "_mul_b"}, bus.mul_b, '0);
   endtask

   int launch0;

   initial begin
      bus.req_valid = '1;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      bus.req_valid = '0;
      rst_n = 1'b1;

      // all four requesters held: rotation 0,1,2,3,0 and squares
      clear_log();
      for (int k = 0; k < N; k++) set_req(k, W'(k + 1), W'(k + 1));
      wait_grants(5, 200);
      wait_results(5, 100);
      check("rr_g0", 64'(grants[0]), 64'd0);
      check("rr_g1", 64'(grants[1]), 64'd1);
      check("rr_g2", 64'(grants[2]), 64'd2);
      check("rr_g3", 64'(grants[3]), 64'd3);
      check("rr_g4", 64'(grants[4]), 64'd0);
      check("sq_1", results[0], 64'd1);
      check("sq_4", results[1], 64'd4);
      check("sq_9", results[2], 64'd9);
      check("sq_16", results[3], 64'd16);

      // single request on line 0
      clear_log();
      launch0 = n_launch;
      set_req(0, 32'd7, 32'd6);
      wait_grants(1, 50);
      wait_results(1, 50);
      check("single_r", results[0], 64'd42);
      check("single_err", 64'(errs[0]), 64'd0);
      check("single_launches", 64'(n_launch - launch0), 64'd1);

      // mul_valid_out still high from the previous op at the start of the next
      clear_log();
      mul_mode = 1;
      mul_lat  = 3;
      set_req(1, 32'd5, 32'd5);
      wait_grants(1, 50);
      wait_results(1, 50);
      set_req(1, 32'hFFFF_FFFF, 32'd2);
      wait_grants(2, 50);
      wait_results(2, 50);
      check("stale_first", results[0], 64'd25);
      check("stale_second", results[1], 64'h1_FFFF_FFFE);

      // multiplier never completes, then a normal op
      clear_log();
      mul_mode = 2;
      set_req(3, 32'd3, 32'd3);
      wait_grants(1, 50);
      wait_results(1, 100);
      check("tout_err", 64'(errs[0]), 64'd1);
      check("tout_r", results[0], 64'd0);
      mul_mode = 0;
      mul_lat  = 2;
      set_req(0, 32'd10, 32'd11);
      wait_grants(2, 50);
      wait_results(2, 50);
      check("after_tout_r", results[1], 64'd110);
      check("after_tout_err", 64'(errs[1]), 64'd0);

      // response back-pressure with competing requests
      clear_log();
      bus.rsp_ready[2] = 1'b0;
      set_req(2, 32'd100, 32'd3);
      wait_grants(1, 50);
      for (int i = 0; i < 50 && !bus.rsp_valid[2]; i++) begin
         @(posedge clk); #1;
      end
      set_req(0, 32'd2, 32'd8);
      set_req(3, 32'd4, 32'd4);
      repeat (10) @(posedge clk);
      #1;
      check("hold_valid", bus.rsp_valid, 4'b0100);
      check("hold_r", bus.rsp_r, 64'd300);
      check("hold_nogrant", 64'(grants.size()), 64'd1);
      bus.rsp_ready[2] = 1'b1;
      wait_grants(3, 50);
      wait_results(3, 50);
      check("hold_g1", 64'(grants[1]), 64'd3);
      check("hold_g2", 64'(grants[2]), 64'd0);
      check("hold_res0", results[0], 64'd300);

      // reset while waiting on a slow multiplication
      clear_log();
      mul_lat = 20;
      set_req(1, 32'd9, 32'd9);
      wait_grants(1, 50);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      mul_lat = 2;
      clear_log();
      set_req(0, 32'd4, 32'd5);
      set_req(2, 32'd12, 32'd13);
      wait_grants(2, 50);
      wait_results(2, 50);
      check("rst_g0", 64'(grants[0]), 64'd0);
      check("rst_g1", 64'(grants[1]), 64'd2);
      check("rst_r0", results[0], 64'd20);
      check("rst_r1", results[1], 64'd156);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
